// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 8:1 bit mux.
package mux8_arb_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [N_CH-1:0]  req_rot;
  logic [SEL_W-1:0] off;

  assign any = |req;

  // Rotate so ptr lands on bit 0, lowest-index encode, then add ptr back.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_CH; i++)
      req_rot[i] = req[ptr + SEL_W'(i)];
    off = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (req_rot[i]) off = SEL_W'(i);
  end

  assign idx = off + ptr;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of the 8:1 mux select, with a per-grant hold limit and
// a one-cycle turnaround bubble after every release.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             gnt_valid,
  output logic             preempt
);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [7:0]       hold_cnt, hold_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [N_CH-1:0]  grant_nxt;
  logic             gv_nxt, pre_nxt;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_hit, release_c;

  rr_priority_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign hold_hit  = (hold_cnt == HOLD_LIM);
  assign release_c = done | ~req[sel] | hold_hit;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    sel_nxt   = sel;
    grant_nxt = grant;
    gv_nxt    = gnt_valid;
    pre_nxt   = 1'b0;
    case (state)
      ARB_IDLE: begin
        grant_nxt = '0;
        gv_nxt    = 1'b0;
        if (pick_any) begin
          state_nxt           = ARB_GRANT;
          grant_nxt[pick_idx] = 1'b1;
          sel_nxt             = pick_idx;
          gv_nxt              = 1'b1;
          ptr_nxt             = pick_idx + SEL_W'(1);
          hold_nxt            = 8'd1;
        end
      end
      ARB_GRANT: begin
        if (release_c) begin
          state_nxt = ARB_IDLE;
          grant_nxt = '0;
          gv_nxt    = 1'b0;
          // Only a hold-limit release with the owner still asking is a preemption.
          pre_nxt   = ~done & req[sel];
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      sel       <= '0;
      grant     <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      sel       <= sel_nxt;
      grant     <= grant_nxt;
      gnt_valid <= gv_nxt;
      preempt   <= pre_nxt;
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a cycle model queues expected outputs
// per clock, plus directed checks on grant order, preemption and reset.
module tb_mux8_rr_arbiter;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       gnt_valid;
  logic       preempt;

  mux8_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] grant;
    logic       gv;
    logic       pre;
  } exp_t;

  exp_t  sb[$];
  int    order[$];
  int    n_chk = 0;
  int    n_err = 0;
  string phase = "init";

  int         m_ptr, m_sel, m_hold;
  logic [7:0] m_grant;
  logic       m_gv, m_pre;
  logic       prev_gv;
  int         pre_cnt, gv_cycles;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_hold = 0;
    m_grant = '0; m_gv = 1'b0; m_pre = 1'b0;
    prev_gv = 1'b0;
  endtask

  // Advance the model by one edge using the current inputs, then compare the DUT.
  task automatic step();
    exp_t e;
    bit   found;
    if (m_gv) begin
      if (done || !req[m_sel] || m_hold == HOLD) begin
        m_pre   = !done && req[m_sel];
        m_gv    = 1'b0;
        m_grant = '0;
      end else begin
        m_hold++;
        m_pre = 1'b0;
      end
    end else begin
      m_pre = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++)
        if (!found && req[(m_ptr + k) % 8]) begin
          found = 1'b1;
          m_sel = (m_ptr + k) % 8;
        end
      if (found) begin
        m_gv    = 1'b1;
        m_grant = 8'(1 << m_sel);
        m_ptr   = (m_sel + 1) % 8;
        m_hold  = 1;
      end
    end
    e.sel = 3'(m_sel); e.grant = m_grant; e.gv = m_gv; e.pre = m_pre;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cyc", 32'({sel, grant, gnt_valid, preempt}), 32'({e.sel, e.grant, e.gv, e.pre}));
    if (gnt_valid && !prev_gv) order.push_back(int'(sel));
    prev_gv = gnt_valid;
    if (preempt) pre_cnt++;
    if (gnt_valid) gv_cycles++;
  endtask

  initial begin
    reset = 1'b1; req = '0; done = 1'b0;
    model_reset();
    pre_cnt = 0; gv_cycles = 0;
    #12;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_gv", 32'(gnt_valid), 0);
    chk("rst_pre", 32'(preempt), 0);
    @(negedge clk) reset = 1'b0;

    phase = "idle";
    for (int i = 0; i < 10; i++) step();
    chk("no_grant", 32'(gv_cycles), 0);

    phase = "alt";
    req = 8'b1000_0100;
    order.delete();
    for (int g = 0; g < 4; g++) begin
      done = 1'b0; step();
      step();
      done = 1'b1; step();
      done = 1'b0;
    end
    chk("n", 32'(order.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("ord", (i < order.size()) ? order[i] : -1, (i % 2 == 0) ? 2 : 7);

    phase = "hold";
    req = 8'hFF;
    order.delete(); pre_cnt = 0; gv_cycles = 0;
    for (int i = 0; i < 9 * (HOLD + 1); i++) step();
    chk("n", 32'(order.size()), 9);
    for (int i = 0; i < 9; i++)
      chk("ord", (i < order.size()) ? order[i] : -1, i % 8);
    chk("npre", 32'(pre_cnt), 9);
    chk("gv_cycles", 32'(gv_cycles), 9 * HOLD);

    phase = "drop";
    req = 8'b0100_1000;
    order.delete(); pre_cnt = 0;
    step();
    step();
    req = 8'b0100_0000;
    step();
    chk("gv_after_drop", 32'(gnt_valid), 0);
    chk("pre_after_drop", 32'(preempt), 0);
    step();
    req = 8'h00;
    step();
    step();
    chk("n", 32'(order.size()), 2);
    chk("first", (order.size() > 0) ? order[0] : -1, 3);
    chk("next", (order.size() > 1) ? order[1] : -1, 6);
    chk("npre", 32'(pre_cnt), 0);

    phase = "done_at_limit";
    req = 8'h01;
    step();
    for (int i = 1; i < HOLD; i++) step();
    chk("owner", 32'(grant), 32'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("gv", 32'(gnt_valid), 0);
    chk("pre", 32'(preempt), 0);
    req = 8'h00;
    step();

    phase = "async_reset";
    req = 8'b0010_0000;
    step();
    step();
    chk("owner", 32'(grant), 32'h20);
    #2 reset = 1'b1;
    #1;
    chk("grant", 32'(grant), 0);
    chk("gv", 32'(gnt_valid), 0);
    chk("sel", 32'(sel), 0);
    model_reset();
    req = 8'b0010_0001;
    @(negedge clk) reset = 1'b0;
    step();
    chk("first_grant", 32'(grant), 32'h01);
    req = 8'h00;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
